nibble_serial_add_sequencer: RTL and testbench

- Sequences one 4-bit ripple-carry adder slice over a WIDTH-bit operand pair, one nibble per clock, LSB nibble first.
- Carries between nibbles through an internal carry register, so wide add/subtract reuses a single 4-bit adder.
- Sits between an operand producer and a result consumer. Both sides use valid/ready handshakes.
- Supports add, subtract, carry/borrow chaining, and signed-overflow reporting.

---
 rtl/nibble_serial_add_sequencer.sv | 152 +++++++++++++++
 tb/tb_nibble_serial_add_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_add_sequencer.sv
// Serial WIDTH-bit adder/subtractor that reuses one 4-bit ripple-carry slice,
// processing one nibble per clock (LSB first) between valid/ready handshakes.
module nibble_serial_add_sequencer #(
    parameter int WIDTH = 16,
    parameter int NIBS  = WIDTH / 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic             out_ovf,
    output logic             busy
);

    localparam int              IDXW     = (NIBS > 1) ? $clog2(NIBS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    if ((WIDTH % 4) != 0 || WIDTH < 4 || NIBS != WIDTH / 4) begin : g_bad_param
        $error("nibble_serial_add_sequencer: WIDTH must be a multiple of 4 (>= 4) and NIBS = WIDTH/4");
    end

    // Returns {carry out of bit 3, carry into bit 3, sum[3:0]}; the two carries
    // together give signed overflow when this slice holds the MSB nibble.
    function automatic logic [5:0] add4(input logic [3:0] a, input logic [3:0] b,
                                        input logic cin);
        logic [3:0] low;
        logic [4:0] full;
        low  = {1'b0, a[2:0]} + {1'b0, b[2:0]} + {3'b000, cin};
        full = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
        return {full[4], low[3], full[3:0]};
    endfunction

    logic [1:0]       state_q,     state_d;
    logic [IDXW-1:0]  idx_q,       idx_d;
    logic             carry_q,     carry_d;
    logic [WIDTH-1:0] out_sum_q,   out_sum_d;
    logic             out_carry_q, out_carry_d;
    logic             out_ovf_q,   out_ovf_d;
    logic [WIDTH-1:0] a_q,         a_d;
    logic [WIDTH-1:0] b_q,         b_d;
    logic [WIDTH-1:0] acc_q,       acc_d;

    logic [3:0] a_nib;
    logic [3:0] b_nib;
    logic [5:0] slice;

    always_comb begin
        a_nib = 4'h0;
        b_nib = 4'h0;
        for (int i = 0; i < NIBS; i++) begin
            if (idx_q == IDXW'(i)) begin
                a_nib = a_q[i*4 +: 4];
                b_nib = b_q[i*4 +: 4];
            end
        end
        slice = add4(a_nib, b_nib, carry_q);
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        out_sum_d   = out_sum_q;
        out_carry_d = out_carry_q;
        out_ovf_d   = out_ovf_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    // Subtraction folds into addition: invert B and the borrow-in.
                    a_d     = in_a;
                    b_d     = in_b ^ {WIDTH{in_sub}};
                    carry_d = in_cin ^ in_sub;
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                for (int i = 0; i < NIBS; i++) begin
                    if (idx_q == IDXW'(i)) begin
                        acc_d[i*4 +: 4] = slice[3:0];
                    end
                end
                carry_d = slice[5];
                if (idx_q == LAST_IDX) begin
                    out_sum_d   = acc_d;
                    out_carry_d = slice[5];
                    out_ovf_d   = slice[5] ^ slice[4];
                    idx_d       = '0;
                    state_d     = S_DONE;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            out_sum_q   <= '0;
            out_carry_q <= 1'b0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            out_sum_q   <= out_sum_d;
            out_carry_q <= out_carry_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    // Operand and partial-result registers are always rewritten before use.
    always_ff @(posedge clk) begin
        a_q   <= a_d;
        b_q   <= b_d;
        acc_q <= acc_d;
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign out_sum   = out_sum_q;
    assign out_carry = out_carry_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_nibble_serial_add_sequencer.sv
// Bench for nibble_serial_add_sequencer: a 16-bit and a 4-bit instance checked
// every cycle against a cycle-level arithmetic model, plus literal test vectors.
module tb_nibble_serial_add_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        v16 = 1'b0, sub16 = 1'b0, cin16 = 1'b0, ordy16 = 1'b1;
    logic [15:0] a16 = '0, b16 = '0;
    logic        ir16, ov16, c16, o16, bz16;
    logic [15:0] s16;

    logic        v4 = 1'b0, sub4 = 1'b0, cin4 = 1'b0, ordy4 = 1'b1;
    logic [3:0]  a4 = '0, b4 = '0;
    logic        ir4, ov4, c4, o4, bz4;
    logic [3:0]  s4;

    nibble_serial_add_sequencer #(.WIDTH(16)) u16 (
        .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(ir16), .in_a(a16), .in_b(b16),
        .in_sub(sub16), .in_cin(cin16), .out_valid(ov16), .out_ready(ordy16),
        .out_sum(s16), .out_carry(c16), .out_ovf(o16), .busy(bz16));

    nibble_serial_add_sequencer #(.WIDTH(4)) u4 (
        .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(ir4), .in_a(a4), .in_b(b4),
        .in_sub(sub4), .in_cin(cin4), .out_valid(ov4), .out_ready(ordy4),
        .out_sum(s4), .out_carry(c4), .out_ovf(o4), .busy(bz4));

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference arithmetic: {ovf, carry, sum} straight from the two's-complement rules.
    function automatic logic [17:0] model_add(input int w, input logic [15:0] a,
                                              input logic [15:0] b, input bit sub, input bit cin);
        logic [31:0] mask, beff, full, sum;
        bit carry, ovf;
        mask  = (32'd1 << w) - 32'd1;
        beff  = (sub ? ~{16'h0, b} : {16'h0, b}) & mask;
        full  = ({16'h0, a} & mask) + beff + 32'(cin ^ sub);
        sum   = full & mask;
        carry = full[w];
        ovf   = (a[w-1] == beff[w-1]) && (sum[w-1] != a[w-1]);
        return {ovf, carry, sum[15:0]};
    endfunction

    bit          m_busy[2];
    int          m_vcyc[2];
    logic [15:0] p_sum[2], m_sum[2];
    bit          p_c[2], p_o[2], m_c[2], m_o[2];

    task automatic model_step(input int d, input bit v, input logic [15:0] a, input logic [15:0] b,
                              input bit sub, input bit cin, input bit ordy,
                              input bit ir, input bit ov, input bit bz,
                              input logic [15:0] s, input bit c, input bit o);
        int w;
        logic [17:0] r;
        string tag;
        w = (d == 0) ? 16 : 4;
        tag = (d == 0) ? "w16" : "w4";
        if (!rst_n) begin
            m_busy[d] = 0; m_sum[d] = '0; m_c[d] = 0; m_o[d] = 0;
        end else if (m_busy[d] && cyc == m_vcyc[d]) begin
            m_sum[d] = p_sum[d]; m_c[d] = p_c[d]; m_o[d] = p_o[d];
        end
        chk({tag, " in_ready"},  32'(ir), 32'(!m_busy[d]));
        chk({tag, " busy"},      32'(bz), 32'(m_busy[d]));
        chk({tag, " out_valid"}, 32'(ov), 32'(m_busy[d] && cyc >= m_vcyc[d]));
        chk({tag, " out_sum"},   32'(s),  32'(m_sum[d]));
        chk({tag, " out_carry"}, 32'(c),  32'(m_c[d]));
        chk({tag, " out_ovf"},   32'(o),  32'(m_o[d]));
        if (rst_n) begin
            if (!m_busy[d] && v) begin
                r = model_add(w, a, b, sub, cin);
                p_sum[d] = r[15:0]; p_c[d] = r[16]; p_o[d] = r[17];
                m_busy[d] = 1;
                m_vcyc[d] = cyc + w / 4 + 1;
            end else if (m_busy[d] && cyc >= m_vcyc[d] && ordy) begin
                m_busy[d] = 0;
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            model_step(0, v16, a16, b16, sub16, cin16, ordy16, ir16, ov16, bz16, s16, c16, o16);
            model_step(1, v4, {12'h0, a4}, {12'h0, b4}, sub4, cin4, ordy4, ir4, ov4, bz4,
                       {12'h0, s4}, c4, o4);
            cyc++;
        end
    end

    task automatic drive(input int d, input bit v, input logic [15:0] a, input logic [15:0] b,
                         input bit sub, input bit cin);
        if (d == 0) begin
            v16 = v; a16 = a; b16 = b; sub16 = sub; cin16 = cin;
        end else begin
            v4 = v; a4 = a[3:0]; b4 = b[3:0]; sub4 = sub; cin4 = cin;
        end
    endtask

    task automatic set_ordy(input int d, input bit r);
        if (d == 0) ordy16 = r; else ordy4 = r;
    endtask

    function automatic bit get_ir(input int d);
        return (d == 0) ? ir16 : ir4;
    endfunction
    function automatic bit get_ov(input int d);
        return (d == 0) ? ov16 : ov4;
    endfunction
    function automatic logic [15:0] get_sum(input int d);
        return (d == 0) ? s16 : {12'h0, s4};
    endfunction
    function automatic bit get_c(input int d);
        return (d == 0) ? c16 : c4;
    endfunction
    function automatic bit get_o(input int d);
        return (d == 0) ? o16 : o4;
    endfunction

    // One operation: present operands, scramble inputs after accept, measure latency,
    // optionally check literal results and hold the result under backpressure.
    task automatic op(input int d, input logic [15:0] a, input logic [15:0] b,
                      input bit sub, input bit cin, input bit lit,
                      input logic [15:0] es, input bit ec, input bit eo, input bit ck_o,
                      input int hold, input string nm);
        int n;
        int nibs;
        logic [15:0] hs;
        bit hc, ho;
        nibs = (d == 0) ? 4 : 1;
        @(posedge clk); #1;
        drive(d, 1, a, b, sub, cin);
        set_ordy(d, hold == 0);
        @(negedge clk);
        n = 0;
        while (!get_ir(d) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!get_ir(d)) chk({nm, " accept timeout"}, 32'(get_ir(d)), 32'd1);
        @(posedge clk); #1;
        drive(d, 0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        n = 1;
        @(negedge clk);
        while (!get_ov(d) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " latency"}, 32'(n), 32'(nibs + 1));
        if (lit) begin
            chk({nm, " sum"},   32'(get_sum(d)), 32'(es));
            chk({nm, " carry"}, 32'(get_c(d)),   32'(ec));
            if (ck_o) chk({nm, " ovf"}, 32'(get_o(d)), 32'(eo));
        end
        if (hold > 0) begin
            hs = get_sum(d); hc = get_c(d); ho = get_o(d);
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                drive(d, 1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
                @(negedge clk);
                chk({nm, " hold valid"},    32'(get_ov(d)),  32'd1);
                chk({nm, " hold in_ready"}, 32'(get_ir(d)),  32'd0);
                chk({nm, " hold sum"},      32'(get_sum(d)), 32'(hs));
                chk({nm, " hold carry"},    32'(get_c(d)),   32'(hc));
                chk({nm, " hold ovf"},      32'(get_o(d)),   32'(ho));
            end
            @(posedge clk); #1;
            drive(d, 0, 16'h0, 16'h0, 0, 0);
            set_ordy(d, 1);
            @(negedge clk);
            chk({nm, " release valid"}, 32'(get_ov(d)), 32'd1);
            @(negedge clk);
            chk({nm, " idle in_ready"}, 32'(get_ir(d)), 32'd1);
            chk({nm, " idle valid"},    32'(get_ov(d)), 32'd0);
            chk({nm, " idle sum kept"}, 32'(get_sum(d)), 32'(hs));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ra, rb;
        repeat (3) @(posedge clk);
        #1;
        chk("reset in_ready", 32'(ir16), 32'd1);
        chk("reset out_valid", 32'(ov16), 32'd0);
        chk("reset sum", 32'(s16), 32'd0);
        rst_n = 1'b1;

        op(0, 16'h1234, 16'h4321, 0, 0, 1, 16'h5555, 0, 0, 1, 0, "add_nocarry");
        op(0, 16'hFFFF, 16'h0001, 0, 0, 1, 16'h0000, 1, 0, 1, 0, "ripple");
        op(0, 16'h7FFF, 16'h0001, 0, 0, 1, 16'h8000, 0, 1, 1, 0, "add_ovf");
        op(0, 16'h0005, 16'h0007, 1, 0, 1, 16'hFFFE, 0, 0, 1, 0, "sub_borrow");
        op(0, 16'h8000, 16'h0001, 1, 0, 1, 16'h7FFF, 1, 1, 1, 0, "sub_ovf");
        op(0, 16'h0005, 16'h0003, 1, 1, 1, 16'h0001, 1, 0, 0, 0, "sub_bin");
        op(0, 16'h00F0, 16'h0F0F, 0, 0, 1, 16'h0FFF, 0, 0, 1, 10, "backpressure");

        // Abort two cycles into RUN; outputs must clear without waiting for a clock.
        @(posedge clk); #1;
        drive(0, 1, 16'h0FFF, 16'h0001, 0, 1);
        @(negedge clk);
        chk("rst accept ready", 32'(ir16), 32'd1);
        @(posedge clk); #1;
        drive(0, 0, 16'h0, 16'h0, 0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("async rst in_ready", 32'(ir16), 32'd1);
        chk("async rst busy", 32'(bz16), 32'd0);
        chk("async rst out_valid", 32'(ov16), 32'd0);
        chk("async rst sum", 32'(s16), 32'd0);
        chk("async rst carry", 32'(c16), 32'd0);
        chk("async rst ovf", 32'(o16), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        op(0, 16'h0001, 16'h0001, 0, 0, 1, 16'h0002, 0, 0, 1, 0, "after_reset");

        op(1, 16'h000F, 16'h0001, 0, 0, 1, 16'h0000, 1, 0, 1, 0, "w4_F_plus_1");
        op(1, 16'h0007, 16'h0001, 0, 0, 1, 16'h0008, 0, 1, 1, 0, "w4_7_plus_1");

        for (int k = 0; k < 40; k++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            op(0, ra, rb, 1'($urandom), 1'($urandom), 0, 16'h0, 0, 0, 0,
               int'($urandom_range(0, 2)), "rnd16");
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(posedge clk);
        end
        for (int k = 0; k < 25; k++) begin
            op(1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 0, 16'h0, 0, 0, 0,
               int'($urandom_range(0, 2)), "rnd4");
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
